// File: rtl/cbfp_pkg.sv
// rtl/cbfp_pkg.sv - shared widths and types for the CBFP de-normaliser
package cbfp_pkg;

   localparam int CBFP_ARRAY_SIZE = 16;
   localparam int CBFP_ARRAY_NUM  = 4;
   localparam int CBFP_DIN_W      = 11;
   localparam int CBFP_DOUT_W     = 23;
   localparam int CBFP_CNT_W      = 5;
   localparam int CBFP_BEAT_W     = $clog2(CBFP_ARRAY_NUM);

   typedef logic signed [CBFP_DIN_W-1:0]  mant_t;
   typedef logic signed [CBFP_DOUT_W-1:0] samp_t;
   typedef logic        [CBFP_CNT_W-1:0]  cnt_t;
   typedef logic        [CBFP_BEAT_W-1:0] beat_t;

   // Largest useful shift: anything beyond leaves only sign bits.
   localparam cnt_t  CBFP_E_MAX     = cnt_t'(CBFP_DOUT_W - 1);
   localparam beat_t CBFP_BEAT_LAST = beat_t'(CBFP_ARRAY_NUM - 1);

endpackage

// File: rtl/cbfp_lane_shift.sv
// rtl/cbfp_lane_shift.sv - one lane: place mantissa in top bits, arithmetic right shift by saturated exponent
module cbfp_lane_shift
   import cbfp_pkg::*;
(
   input  mant_t din_i,
   input  cnt_t  exp_i,
   output samp_t dout_o
);

   samp_t ext;
   cnt_t  e_sat;

   // Restore the sample: mantissa scaled to full width, then shifted down with sign fill.
   always_comb begin
      ext    = {din_i, {(CBFP_DOUT_W - CBFP_DIN_W){1'b0}}};
      e_sat  = (exp_i > CBFP_E_MAX) ? CBFP_E_MAX : exp_i;
      dout_o = ext >>> e_sat;
   end

endmodule

// File: rtl/cbfp_denorm.sv
// rtl/cbfp_denorm.sv - CBFP de-normaliser top: beat counter, exponent capture, two-stage pipeline
module cbfp_denorm
   import cbfp_pkg::*;
(
   input  logic                         clk,
   input  logic                         rstn,
   input  logic                         valid_in,
   input  mant_t [CBFP_ARRAY_SIZE-1:0]  din_re_p,
   input  mant_t [CBFP_ARRAY_SIZE-1:0]  din_im_p,
   input  cnt_t  [CBFP_ARRAY_NUM-1:0]   zero_cnt,
   output samp_t [CBFP_ARRAY_SIZE-1:0]  dout_re_p,
   output samp_t [CBFP_ARRAY_SIZE-1:0]  dout_im_p,
   output logic                         valid_out,
   output logic                         blk_last
);

   beat_t                        beat_cnt_q, beat_cnt_d;
   cnt_t  [CBFP_ARRAY_NUM-1:0]   exp_q, exp_d;
   cnt_t                         sel_exp;

   logic                         s1_valid_q;
   logic                         s1_last_q;
   cnt_t                         s1_exp_q;
   mant_t [CBFP_ARRAY_SIZE-1:0]  s1_re_q, s1_im_q;

   samp_t [CBFP_ARRAY_SIZE-1:0]  re_sh, im_sh;
   samp_t [CBFP_ARRAY_SIZE-1:0]  dout_re_q, dout_im_q;
   logic                         valid_out_q;
   logic                         blk_last_q;

   // Beat tracking and exponent selection; beat 0 bypasses the exponent registers.
   always_comb begin
      beat_cnt_d = beat_cnt_q;
      exp_d      = exp_q;
      sel_exp    = (beat_cnt_q == '0) ? zero_cnt[0] : exp_q[beat_cnt_q];
      if (valid_in) begin
         beat_cnt_d = (beat_cnt_q == CBFP_BEAT_LAST) ? '0 : beat_cnt_q + beat_t'(1);
         if (beat_cnt_q == '0) begin
            exp_d = zero_cnt;
         end
      end
   end

   // Beat counter and per-block exponent registers.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         beat_cnt_q <= '0;
         exp_q      <= '0;
      end else begin
         beat_cnt_q <= beat_cnt_d;
         exp_q      <= exp_d;
      end
   end

   // Stage 1: capture mantissas with their own exponent copy so a block-start reload cannot disturb them.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         s1_valid_q <= 1'b0;
         s1_last_q  <= 1'b0;
         s1_exp_q   <= '0;
         s1_re_q    <= '0;
         s1_im_q    <= '0;
      end else begin
         s1_valid_q <= valid_in;
         if (valid_in) begin
            s1_last_q <= (beat_cnt_q == CBFP_BEAT_LAST);
            s1_exp_q  <= sel_exp;
            s1_re_q   <= din_re_p;
            s1_im_q   <= din_im_p;
         end
      end
   end

   for (genvar g = 0; g < CBFP_ARRAY_SIZE; g++) begin : g_lane
      cbfp_lane_shift u_re (
         .din_i  (s1_re_q[g]),
         .exp_i  (s1_exp_q),
         .dout_o (re_sh[g])
      );
      cbfp_lane_shift u_im (
         .din_i  (s1_im_q[g]),
         .exp_i  (s1_exp_q),
         .dout_o (im_sh[g])
      );
   end

   // Stage 2: register shifted samples; outputs hold their last value between beats.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         valid_out_q <= 1'b0;
         blk_last_q  <= 1'b0;
         dout_re_q   <= '0;
         dout_im_q   <= '0;
      end else begin
         valid_out_q <= s1_valid_q;
         blk_last_q  <= s1_valid_q & s1_last_q;
         if (s1_valid_q) begin
            dout_re_q <= re_sh;
            dout_im_q <= im_sh;
         end
      end
   end

   assign dout_re_p = dout_re_q;
   assign dout_im_p = dout_im_q;
   assign valid_out = valid_out_q;
   assign blk_last  = blk_last_q;

endmodule
